// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the width of the shift counter.
package shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Enough bits to count 0..width.
   function automatic int cw_of(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-left / shift-right / parallel load,
// with a shift counter that pulses frame_done on every WIDTH-th shift.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              CW      = cw_of(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             si_l,
   input  logic             si_r,
   input  logic [WIDTH-1:0] pdata_in,
   output logic [WIDTH-1:0] q,
   output logic             so_l,
   output logic             so_r,
   output logic [CW-1:0]    shift_cnt,
   output logic             frame_done
);

   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shl_val;
   logic [WIDTH-1:0] shr_val;

   // A single-bit register has no neighbours; serial input replaces it outright.
   generate
      if (WIDTH == 1) begin : g_w1
         assign shl_val = si_l;
         assign shr_val = si_r;
      end else begin : g_wn
         assign shl_val = {q[WIDTH-2:0], si_l};
         assign shr_val = {si_r, q[WIDTH-1:1]};
      end
   endgenerate

   assign so_l = q[WIDTH-1];
   assign so_r = q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         case (mode)
            MODE_SHL:  q <= shl_val;
            MODE_SHR:  q <= shr_val;
            MODE_LOAD: q <= pdata_in;
            default:   q <= q;
         endcase
      end
   end

   // Both shift directions count toward the same frame; LOAD restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_cnt  <= '0;
         frame_done <= 1'b0;
      end else if (!en) begin
         frame_done <= 1'b0;
      end else begin
         case (mode)
            MODE_SHL, MODE_SHR: begin
               if (shift_cnt == LAST_CNT) begin
                  shift_cnt  <= '0;
                  frame_done <= 1'b1;
               end else begin
                  shift_cnt  <= shift_cnt + CW'(1);
                  frame_done <= 1'b0;
               end
            end
            MODE_LOAD: begin
               shift_cnt  <= '0;
               frame_done <= 1'b0;
            end
            default: frame_done <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8 (RST_VAL=A5) and WIDTH=1 (RST_VAL=1).
module tb_univ_shift_reg;

   localparam logic [1:0] HOLD = 2'b00, SHL = 2'b01, SHR = 2'b10, LOAD = 2'b11;

   logic       clk = 1'b0;
   logic       rst, en, si_l, si_r;
   logic [1:0] mode;
   logic [7:0] pdata_in, q;
   logic       so_l, so_r, frame_done;
   logic [3:0] shift_cnt;

   logic       rst1, en1, si_l1, si_r1, pd1, q1, so_l1, so_r1, fd1;
   logic [1:0] mode1;
   logic [0:0] cnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .si_l(si_l), .si_r(si_r),
      .pdata_in(pdata_in), .q(q), .so_l(so_l), .so_r(so_r),
      .shift_cnt(shift_cnt), .frame_done(frame_done)
   );

   univ_shift_reg #(.WIDTH(1), .RST_VAL(1'b1)) dut1 (
      .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .si_l(si_l1), .si_r(si_r1),
      .pdata_in(pd1), .q(q1), .so_l(so_l1), .so_r(so_r1),
      .shift_cnt(cnt1), .frame_done(fd1)
   );

   typedef struct {
      logic       rst, en;
      logic [1:0] mode;
      logic       sl, sr;
      logic [7:0] pd;
      logic [7:0] q;
      logic [3:0] cnt;
      logic       fd;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                               input logic sl, input logic sr, input logic [7:0] pd,
                               input logic [7:0] eq, input logic [3:0] ec, input logic ef);
      vec_t v;
      v.rst = r; v.en = e; v.mode = m; v.sl = sl; v.sr = sr; v.pd = pd;
      v.q = eq; v.cnt = ec; v.fd = ef;
      return v;
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step8(input logic r, input logic e, input logic [1:0] m,
                        input logic sl, input logic sr, input logic [7:0] pd);
      rst = r; en = e; mode = m; si_l = sl; si_r = sr; pdata_in = pd;
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic r, input logic e, input logic [1:0] m,
                        input logic sl, input logic sr, input logic pd);
      rst1 = r; en1 = e; mode1 = m; si_l1 = sl; si_r1 = sr; pd1 = pd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = HOLD; si_l = 1'b0; si_r = 1'b0; pdata_in = '0;
      rst1 = 1'b1; en1 = 1'b0; mode1 = HOLD; si_l1 = 1'b0; si_r1 = 1'b0; pd1 = 1'b0;
      #1;

      // Reset, LOAD B4 + 8x SHR, 7 shifts then LOAD collision, en=0 blocks LOAD.
      tbl.push_back(mk(1, 0, HOLD, 0, 0, 8'h00, 8'hA5, 0, 0));
      tbl.push_back(mk(1, 1, SHL,  1, 0, 8'h00, 8'hA5, 0, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 0, 8'hB4, 8'hB4, 0, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h5A, 1, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h2D, 2, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h16, 3, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h0B, 4, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h05, 5, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h02, 6, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h01, 7, 0));
      tbl.push_back(mk(0, 1, SHR,  0, 0, 8'h00, 8'h00, 0, 1));
      tbl.push_back(mk(0, 1, HOLD, 0, 0, 8'h00, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h01, 1, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h03, 2, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h07, 3, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h0F, 4, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h1F, 5, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h3F, 6, 0));
      tbl.push_back(mk(0, 1, SHL,  1, 0, 8'h00, 8'h7F, 7, 0));
      tbl.push_back(mk(0, 1, LOAD, 0, 0, 8'h3C, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 1, HOLD, 0, 0, 8'h00, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 0, LOAD, 1, 1, 8'hFF, 8'h3C, 0, 0));

      foreach (tbl[i]) begin
         step8(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].sl, tbl[i].sr, tbl[i].pd);
         chk($sformatf("vec%0d_q", i), q, tbl[i].q);
         chk($sformatf("vec%0d_cnt", i), shift_cnt, tbl[i].cnt);
         chk($sformatf("vec%0d_fd", i), frame_done, tbl[i].fd);
         chk($sformatf("vec%0d_so_r", i), so_r, tbl[i].q[0]);
         chk($sformatf("vec%0d_so_l", i), so_l, tbl[i].q[7]);
      end

      // SHL latency: a single 1 on si_l reaches so_l after exactly 8 shifts.
      step8(0, 1, LOAD, 0, 0, 8'h00);
      for (int k = 1; k <= 8; k++) begin
         step8(0, 1, SHL, (k == 1), 0, 8'h00);
         chk($sformatf("lat_so_l_k%0d", k), so_l, (k == 8));
         chk($sformatf("lat_fd_k%0d", k), frame_done, (k == 8));
      end
      step8(0, 1, HOLD, 0, 0, 8'h00);
      chk("lat_fd_after", frame_done, 0);

      // en gating with mixed directions: 3 SHL, 5 idle, 5 SHR completes a frame.
      step8(0, 1, LOAD, 0, 0, 8'h81);
      step8(0, 1, SHL, 0, 0, 8'h00);
      step8(0, 1, SHL, 0, 0, 8'h00);
      step8(0, 1, SHL, 0, 0, 8'h00);
      chk("mix_q_shl", q, 8'h08);
      chk("mix_cnt_shl", shift_cnt, 3);
      for (int k = 0; k < 5; k++) begin
         step8(0, 0, SHL, 1, 1, 8'h00);
         chk($sformatf("mix_hold_cnt%0d", k), shift_cnt, 3);
         chk($sformatf("mix_hold_q%0d", k), q, 8'h08);
         chk($sformatf("mix_hold_fd%0d", k), frame_done, 0);
      end
      begin
         logic [7:0] exp_q [5] = '{8'h84, 8'hC2, 8'hE1, 8'hF0, 8'hF8};
         for (int k = 0; k < 5; k++) begin
            step8(0, 1, SHR, 0, 1, 8'h00);
            chk($sformatf("mix_shr_q%0d", k), q, exp_q[k]);
            chk($sformatf("mix_shr_cnt%0d", k), shift_cnt, (k + 4) % 8);
            chk($sformatf("mix_shr_fd%0d", k), frame_done, (k == 4));
         end
      end

      // Reset mid-frame discards the partial count.
      step8(0, 1, LOAD, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) step8(0, 1, SHL, 1, 0, 8'h00);
      chk("rmid_cnt_pre", shift_cnt, 4);
      step8(1, 1, SHL, 1, 0, 8'h00);
      chk("rmid_q", q, 8'hA5);
      chk("rmid_cnt", shift_cnt, 0);
      for (int k = 1; k <= 8; k++) begin
         step8(0, 1, SHL, 0, 0, 8'h00);
         chk($sformatf("rmid_fd_k%0d", k), frame_done, (k == 8));
         chk($sformatf("rmid_cnt_k%0d", k), shift_cnt, k % 8);
      end
      step8(0, 0, HOLD, 0, 0, 8'h00);
      chk("rmid_fd_en0", frame_done, 0);

      // WIDTH=1: every shift completes a frame.
      step1(1, 0, HOLD, 0, 0, 0);
      chk("w1_rst_q", q1, 1);
      chk("w1_rst_cnt", cnt1, 0);
      chk("w1_rst_fd", fd1, 0);
      step1(0, 1, SHL, 0, 1, 1);
      chk("w1_shl_q", q1, 0);
      chk("w1_shl_so_l", so_l1, 0);
      chk("w1_shl_fd", fd1, 1);
      chk("w1_shl_cnt", cnt1, 0);
      step1(0, 1, SHR, 0, 1, 0);
      chk("w1_shr_q", q1, 1);
      chk("w1_shr_so_r", so_r1, 1);
      chk("w1_shr_fd", fd1, 1);
      step1(0, 1, HOLD, 0, 0, 0);
      chk("w1_hold_q", q1, 1);
      chk("w1_hold_fd", fd1, 0);
      step1(0, 1, LOAD, 1, 1, 0);
      chk("w1_load_q", q1, 0);
      chk("w1_load_fd", fd1, 0);
      step1(0, 0, SHL, 1, 1, 1);
      chk("w1_en0_q", q1, 0);
      chk("w1_en0_fd", fd1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
